// File: rtl/data_memory_master.sv
// Initiator for the data-memory port: one load/store at a time, ISSUE strobe then WAIT for ready.
// Define MEM_TIMEOUT_EN to abandon accesses after TIMEOUT_CYCLES stalled WAIT cycles.
module data_memory_master #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                op_write_q, op_write_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                resp_valid_q, resp_valid_d;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                resp_error_q, resp_error_d;
`else
  logic                unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    op_write_d   = op_write_q;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    resp_valid_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d        = cnt_q;
    resp_error_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          op_write_d = req_write;
          rd_d       = ~req_write;
          wr_d       = req_write;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        // mem_ready is deliberately ignored here so a stale ready cannot complete this access.
        state_d = StWait;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        if (mem_ready) begin
          if (!op_write_q) rdata_d = mem_out;
          resp_valid_d = 1'b1;
          state_d      = StIdle;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          resp_valid_d = 1'b1;
          resp_error_d = 1'b1;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      op_write_q   <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      resp_valid_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= '0;
      resp_error_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      op_write_q   <= op_write_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      resp_valid_q <= resp_valid_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= cnt_d;
      resp_error_q <= resp_error_d;
`endif
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = rdata_q;
  assign mem_address = addr_q;
  assign mem_in      = wdata_q;
  assign mem_read    = rd_q;
  assign mem_write   = wr_q;
`ifdef MEM_TIMEOUT_EN
  assign resp_error  = resp_error_q;
`else
  assign resp_error  = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_master.sv
// Self-checking bench for data_memory_master: vector table + scoreboard, memory stub model.
module tb_data_memory_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       resp_valid, resp_error;
  logic [7:0] resp_rdata;
  logic [7:0] mem_address, mem_in, mem_out;
  logic       mem_read, mem_write, mem_ready;

  data_memory_master dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .mem_address(mem_address),
    .mem_in     (mem_in),
    .mem_out    (mem_out),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory stub: performs the op at the closing edge of the strobe cycle.
  logic [7:0] mem [256];
  int wr_cnt = 0;
  int rd_cnt = 0;
  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_address] <= mem_in;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_read) begin
      mem_out <= mem[mem_address];
      rd_cnt  <= rd_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         acc;
    int         lat;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read || mem_write) check("strobe_exclusive", {31'd0, mem_read & mem_write}, 0);
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.lat >= 0) check("resp_latency", cyc - e.acc, e.lat);
          check("resp_error", {31'd0, resp_error}, {31'd0, e.err});
          check("resp_rdata", {24'd0, resp_rdata}, {24'd0, e.rdata});
        end
      end
    end
  end

  task automatic do_req(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rdata, input logic exp_err, input int lat,
                        output int acc);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_timeout", 0, 1);
    acc     = cyc + 1;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.acc   = acc;
    e.lat   = lat;
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic drop_req();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},   {31'd0, req_ready},  1);
    check({tag, "_mem_read"},    {31'd0, mem_read},   0);
    check({tag, "_mem_write"},   {31'd0, mem_write},  0);
    check({tag, "_mem_address"}, {24'd0, mem_address}, 0);
    check({tag, "_mem_in"},      {24'd0, mem_in},     0);
    check({tag, "_resp_valid"},  {31'd0, resp_valid}, 0);
    check({tag, "_resp_rdata"},  {24'd0, resp_rdata}, 0);
    check({tag, "_resp_error"},  {31'd0, resp_error}, 0);
  endtask

  typedef struct {
    logic       w;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;
  vec_t vecs[9];

  initial begin
    int acc, prev_acc;
    vecs[0] = '{1'b1, 8'h10, 8'h5A, 8'h00};
    vecs[1] = '{1'b0, 8'h10, 8'h00, 8'h5A};
    vecs[2] = '{1'b1, 8'h20, 8'h11, 8'h5A};
    vecs[3] = '{1'b1, 8'h20, 8'h22, 8'h5A};
    vecs[4] = '{1'b0, 8'h20, 8'h00, 8'h22};
    vecs[5] = '{1'b0, 8'h10, 8'h00, 8'h5A};
    vecs[6] = '{1'b1, 8'h33, 8'hC3, 8'h5A};
    vecs[7] = '{1'b0, 8'h33, 8'h00, 8'hC3};
    vecs[8] = '{1'b0, 8'h20, 8'h00, 8'h22};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    mem_ready = 1'b1;

    // Reset held, then released with no request
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_release");

    // Back-to-back table with mem_ready stuck high; the requester holds req_valid throughout
    prev_acc = 0;
    for (int i = 0; i < 9; i++) begin
      do_req(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1'b0, 2, acc);
      if (i > 0) check("accept_spacing", acc - prev_acc, 3);
      prev_acc = acc;
    end
    drop_req();
    drain(20);
    check("write_strobes", wr_cnt, 4);
    check("read_strobes", rd_cnt, 5);
    check("mem_0x10", {24'd0, mem[8'h10]}, 32'h5A);
    check("mem_0x20", {24'd0, mem[8'h20]}, 32'h22);
    check("mem_0x33", {24'd0, mem[8'h33]}, 32'hC3);

    // Reset asserted while a load stalls in WAIT
    mem_ready = 1'b0;
    do_req(1'b0, 8'h20, 8'h00, 8'h22, 1'b0, 2, acc);
    drop_req();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    do_req(1'b0, 8'h10, 8'h00, 8'h5A, 1'b0, 2, acc);
    drop_req();
    drain(20);

    // Memory never ready
    mem_ready = 1'b0;
`ifdef MEM_TIMEOUT_EN
    do_req(1'b0, 8'h33, 8'h00, 8'h5A, 1'b1, 16, acc);
    drop_req();
    drain(40);
    check("rdata_after_timeout", {24'd0, resp_rdata}, 32'h5A);
`else
    do_req(1'b0, 8'h33, 8'h00, 8'hC3, 1'b0, -1, acc);
    drop_req();
    repeat (100) @(negedge clk);
    check("stall_pending", sb.size(), 1);
    check("stall_busy", {31'd0, req_ready}, 0);
    mem_ready = 1'b1;
    drain(10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
